// File: rtl/trace_packer.sv
// Trace packer: accepts 1..4-halfword trace packets in a single cycle and
// queues them in a halfword FIFO. A packet either fits completely or is
// dropped and counted. The FIFO drains one halfword per accepted handshake.
module trace_packer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     flush_i,
    input  logic [63:0]              packet_i,
    input  logic [2:0]               packet_len_i,
    input  logic                     packet_valid_i,
    output logic [15:0]              data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [FW-1:0] free;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          overflow_q, overflow_d;
    logic          push_req, len_ok, push_ok, drop, pop;

    // Output view of the FIFO head; empty FIFO shows zero so reset/flush read back 0x0000.
    always_comb begin
        valid_o    = (fill_q != '0);
        data_o     = valid_o ? mem_q[rd_ptr_q] : 16'h0000;
        fill_o     = fill_q;
        drop_cnt_o = drop_cnt_q;
        overflow_o = overflow_q;
    end

    // Push/drop decision and next-state; space check uses start-of-cycle fill,
    // so a same-cycle pop never makes room for the incoming packet.
    always_comb begin
        push_req   = packet_valid_i & enable_i & ~flush_i;
        len_ok     = (packet_len_i != 3'd0) && (packet_len_i <= 3'd4);
        free       = FW'(DEPTH) - fill_q;
        push_ok    = push_req & len_ok & (FW'(packet_len_i) <= free);
        drop       = push_req & (packet_len_i != 3'd0) & ~push_ok;
        pop        = valid_o & ready_i;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_d     = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(packet_len_i);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            fill_d = fill_q + (push_ok ? FW'(packet_len_i) : FW'(0)) - (pop ? FW'(1) : FW'(0));
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
    end

    // Control state; async reset discards FIFO contents immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write: the whole packet lands in one cycle, halfword 0 at the write pointer.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < packet_len_i) begin
                    mem_q[wr_ptr_q + AW'(k)] <= packet_i[16*k +: 16];
                end
            end
        end
    end

endmodule

// File: tb/tb_trace_packer.sv
// Directed bench for trace_packer: a per-cycle vector table followed by a
// scoreboarded ready-toggling stream and a mid-drain reset.
module tb_trace_packer;

    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i, flush_i, packet_valid_i, ready_i;
    logic [63:0] packet_i;
    logic [2:0]  packet_len_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic [4:0]  fill_o;
    logic [15:0] drop_cnt_o;
    logic        overflow_o;

    trace_packer #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .flush_i       (flush_i),
        .packet_i      (packet_i),
        .packet_len_i  (packet_len_i),
        .packet_valid_i(packet_valid_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .fill_o        (fill_o),
        .drop_cnt_o    (drop_cnt_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        fl, en, pv;
        logic [2:0]  len;
        logic [63:0] pkt;
        logic        rdy;
        logic        ev;
        logic [15:0] ed;
        logic [4:0]  ef;
        logic [15:0] edc;
        logic        eo;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic fl, input logic en, input logic pv, input logic [2:0] len,
                       input logic [63:0] pkt, input logic rdy, input logic ev,
                       input logic [15:0] ed, input logic [4:0] ef, input logic [15:0] edc,
                       input logic eo);
        vec_t v;
        v.fl = fl; v.en = en; v.pv = pv; v.len = len; v.pkt = pkt; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ef = ef; v.edc = edc; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [15:0] ed,
                              input logic [4:0] ef, input logic [15:0] edc, input logic eo);
        check({tag, " valid"}, 32'(valid_o), 32'(ev));
        check({tag, " data"},  32'(data_o), 32'(ed));
        check({tag, " fill"},  32'(fill_o), 32'(ef));
        check({tag, " drop"},  32'(drop_cnt_o), 32'(edc));
        check({tag, " ovf"},   32'(overflow_o), 32'(eo));
    endtask

    logic [15:0] q[$];
    logic [15:0] hw;
    logic [15:0] prev_data;
    logic        prev_stall;
    int          drops;

    initial begin
        // Columns: flush en pvalid len packet ready | exp valid data fill drop ovf
        // Outputs are those seen during the cycle the inputs are applied.
        add(1'b0,1'b1,1'b1,3'd4,64'h4444_3333_2222_1111,1'b1, 1'b0,16'h0000,5'd0, 16'd0,1'b0);
        add(1'b0,1'b1,1'b0,3'd0,64'h0,                  1'b1, 1'b1,16'h1111,5'd4, 16'd0,1'b0);
        add(1'b0,1'b1,1'b0,3'd0,64'h0,                  1'b1, 1'b1,16'h2222,5'd3, 16'd0,1'b0);
        add(1'b0,1'b1,1'b0,3'd0,64'h0,                  1'b1, 1'b1,16'h3333,5'd2, 16'd0,1'b0);
        add(1'b0,1'b1,1'b0,3'd0,64'h0,                  1'b1, 1'b1,16'h4444,5'd1, 16'd0,1'b0);
        add(1'b0,1'b1,1'b1,3'd4,64'h1004_1003_1002_1001,1'b0, 1'b0,16'h0000,5'd0, 16'd0,1'b0);
        add(1'b0,1'b1,1'b1,3'd4,64'h2004_2003_2002_2001,1'b0, 1'b1,16'h1001,5'd4, 16'd0,1'b0);
        add(1'b0,1'b1,1'b1,3'd4,64'h3004_3003_3002_3001,1'b0, 1'b1,16'h1001,5'd8, 16'd0,1'b0);
        add(1'b0,1'b1,1'b1,3'd4,64'h4004_4003_4002_4001,1'b0, 1'b1,16'h1001,5'd12,16'd0,1'b0);
        add(1'b0,1'b1,1'b1,3'd4,64'h5004_5003_5002_5001,1'b0, 1'b1,16'h1001,5'd16,16'd0,1'b0);
        add(1'b0,1'b1,1'b0,3'd0,64'h0,                  1'b1, 1'b1,16'h1001,5'd16,16'd1,1'b1);
        add(1'b0,1'b1,1'b0,3'd0,64'h0,                  1'b1, 1'b1,16'h1002,5'd15,16'd1,1'b1);
        add(1'b0,1'b1,1'b1,3'd3,64'h0000_6003_6002_6001,1'b1, 1'b1,16'h1003,5'd14,16'd1,1'b1);
        add(1'b0,1'b1,1'b1,3'd0,64'hFFFF_FFFF_FFFF_FFFF,1'b0, 1'b1,16'h1004,5'd13,16'd2,1'b1);
        add(1'b0,1'b1,1'b1,3'd6,64'h7004_7003_7002_7001,1'b0, 1'b1,16'h1004,5'd13,16'd2,1'b1);
        add(1'b0,1'b1,1'b1,3'd3,64'h0000_8003_8002_8001,1'b0, 1'b1,16'h1004,5'd13,16'd3,1'b1);
        add(1'b0,1'b0,1'b1,3'd1,64'h0000_0000_0000_7777,1'b1, 1'b1,16'h1004,5'd16,16'd3,1'b1);
        add(1'b1,1'b1,1'b1,3'd1,64'h0000_0000_0000_8888,1'b1, 1'b1,16'h2001,5'd15,16'd3,1'b1);
        add(1'b0,1'b1,1'b1,3'd1,64'h0000_0000_0000_0ABC,1'b0, 1'b0,16'h0000,5'd0, 16'd0,1'b0);
        add(1'b0,1'b1,1'b0,3'd0,64'h0,                  1'b1, 1'b1,16'h0ABC,5'd1, 16'd0,1'b0);
        add(1'b0,1'b1,1'b0,3'd0,64'h0,                  1'b1, 1'b0,16'h0000,5'd0, 16'd0,1'b0);

        rst_ni = 1'b0; enable_i = 1'b1; flush_i = 1'b0; packet_valid_i = 1'b0;
        packet_i = '0; packet_len_i = '0; ready_i = 1'b0;
        @(negedge clk_i);
        check_outs("reset", 1'b0, 16'h0000, 5'd0, 16'd0, 1'b0);
        rst_ni = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk_i);
            check_outs($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ef, tbl[i].edc, tbl[i].eo);
            flush_i        = tbl[i].fl;
            enable_i       = tbl[i].en;
            packet_valid_i = tbl[i].pv;
            packet_len_i   = tbl[i].len;
            packet_i       = tbl[i].pkt;
            ready_i        = tbl[i].rdy;
        end

        // Continuous len-2 pushes with ready toggling; scoreboard follows the
        // FIFO semantics (start-of-cycle space check, all-or-nothing push).
        hw = 16'h0100;
        drops = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            check($sformatf("stream%0d valid", c), 32'(valid_o), 32'(q.size() != 0));
            check($sformatf("stream%0d fill", c), 32'(fill_o), 32'(q.size()));
            if (q.size() != 0) begin
                check($sformatf("stream%0d data", c), 32'(data_o), 32'(q[0]));
                if (prev_stall)
                    check($sformatf("stream%0d stable", c), 32'(data_o), 32'(prev_data));
            end
            flush_i = 1'b0; enable_i = 1'b1; packet_valid_i = 1'b1;
            packet_len_i = 3'd2;
            packet_i = {32'h0, hw + 16'd1, hw};
            ready_i = (c % 2 == 0);
            prev_stall = (q.size() != 0) && !ready_i;
            prev_data = data_o;
            if (q.size() != 0 && ready_i) void'(q.pop_front());
            if (DEPTH - (q.size() + ((q.size() != 0 && ready_i) ? 1 : 0)) >= 2) begin
                q.push_back(hw);
                q.push_back(hw + 16'd1);
            end else begin
                drops++;
            end
            hw = hw + 16'd2;
        end
        @(negedge clk_i);
        packet_valid_i = 1'b0; ready_i = 1'b0;
        check("stream drops", 32'(drop_cnt_o), 32'(drops));
        check("stream ovf", 32'(overflow_o), 32'(drops != 0));
        check("stream head", 32'(data_o), 32'(q[0]));

        // Reset in the middle of a drain: contents vanish, nothing emitted after release.
        @(negedge clk_i);
        ready_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_outs("midreset", 1'b0, 16'h0000, 5'd0, 16'd0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check($sformatf("postreset%0d valid", c), 32'(valid_o), 32'(0));
            check($sformatf("postreset%0d fill", c), 32'(fill_o), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trace_packer.md
TRACE_PACKER -- requirements
Module: trace_packer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO capacity in 16-bit halfwords; power of two, minimum 4.
REQ-002 clk_i  in  1  clock; all state on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 enable_i  in  1  1 = accept packets; 0 = ignore packet_valid_i (FIFO still drains).
REQ-005 flush_i  in  1  synchronous clear of FIFO contents.
REQ-006 packet_i  in  64  trace packet; halfword k = packet_i[16k+15:16k].
REQ-007 packet_len_i  in  3  packet length in halfwords, legal 1..4.
REQ-008 packet_valid_i  in  1  packet present this cycle; no backpressure to source.
REQ-009 data_o  out  16  halfword to udma rx channel (feeds data_rx_data).
REQ-010 valid_o  out  1  data_o valid.
REQ-011 ready_i  in  1  consumer accepts data_o.
REQ-012 fill_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 drop_cnt_o  out  16  dropped-packet count, saturating.
REQ-014 overflow_o  out  1  sticky: at least one packet dropped since reset/flush.

Function
REQ-015 Push condition: packet_valid_i & enable_i & ~flush_i; evaluated each cycle.
REQ-016 Legal push with packet_len_i <= DEPTH - fill (fill = value at start of cycle) SHALL write halfwords 0..len-1 in order, halfword 0 first out.
REQ-017 Pushes are all-or-nothing: no partial packet ever enters the FIFO.
REQ-018 Push with insufficient space, or packet_len_i in {5,6,7}, SHALL drop the whole packet, increment drop_cnt_o (saturate at 0xFFFF) and set overflow_o.
REQ-019 Push with packet_len_i = 0 SHALL be ignored: no write, no drop count.
REQ-020 Pop occurs when valid_o & ready_i; data_o advances to next halfword next cycle.
REQ-021 valid_o = (fill != 0); data_o = head entry, registered; data_o holds stable while valid_o & ~ready_i.
REQ-022 Latency: halfword 0 of a packet pushed into empty FIFO at cycle N appears on data_o/valid_o at cycle N+1.
REQ-023 Simultaneous push and pop: space check uses start-of-cycle fill (pop frees no space same cycle); fill_next = fill + len - pop.
REQ-024 Read/write pointers wrap modulo DEPTH; full (fill = DEPTH) and empty (fill = 0) distinguished by fill counter, not pointers.
REQ-025 valid_o SHALL never assert when empty; pop with fill = 0 impossible by construction.
REQ-026 flush_i SHALL have priority over push and pop: next cycle fill = 0, valid_o = 0, drop_cnt_o = 0, overflow_o = 0; any same-cycle packet discarded and not counted.
REQ-027 enable_i = 0 SHALL not affect drain, counters or overflow_o.
REQ-028 drop_cnt_o and overflow_o change only via REQ-018 and REQ-026 or reset.

Reset
REQ-029 While rst_ni = 0: valid_o = 0, data_o = 0x0000, fill_o = 0, drop_cnt_o = 0, overflow_o = 0, pointers = 0.
REQ-030 Reset asserted mid-operation SHALL discard FIFO contents immediately; no halfword emitted after release until a new push.

Verification
REQ-031 Empty FIFO, ready_i = 1, push packet_i = 0x4444_3333_2222_1111 len 4 at cycle 0 -> data_o 0x1111,0x2222,0x3333,0x4444 on cycles 1-4, valid_o low cycle 5, fill_o peaks 4.
REQ-032 DEPTH=16, ready_i = 0, push five len-4 packets -> first four stored (fill_o = 16), fifth dropped, drop_cnt_o = 1, overflow_o = 1.
REQ-033 fill = 14, ready_i = 1, push len 3 same cycle as pop -> dropped (start-of-cycle free = 2), fill_o = 13 next cycle, drop_cnt_o +1.
REQ-034 Push len 0 and len 6 -> len 0: no change; len 6: drop_cnt_o +1, no FIFO write.
REQ-035 ready_i toggling 1/0 over 40 cycles with continuous len-2 pushes -> output sequence equals input halfword order across pointer wrap, data_o stable on stalled cycles.
REQ-036 Fill = 8, overflow_o = 1, flush_i and push same cycle -> next cycle fill_o = 0, valid_o = 0, drop_cnt_o = 0, overflow_o = 0; rst_ni pulse mid-drain -> same outputs, no further halfwords.
